inst_fetch_unit: RTL

//  Instruction-fetch stage directly downstream of the PC register. Takes PC/PCPlus4/PCTLBMiss,

---
 rtl/inst_fetch_unit.sv | 127 ++++++++++++
 1 files changed

// File: rtl/inst_fetch_unit.sv
// Instruction-fetch stage: one bus read per PC, IF/ID register with flush/pause,
// TLB-miss bypass and bus timeout. ready tells the PC register a fetch has resolved.
module inst_fetch_unit #(
    parameter int BUS_TIMEOUT = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] PC,
    input  logic [31:0] PCPlus4,
    input  logic        PCTLBMiss,
    input  logic        flush,
    input  logic        PauseSignal,
    output logic        ready,
    output logic        bus_req,
    output logic [31:0] bus_addr,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [31:0] inst_pc_plus4,
    output logic        inst_tlb_miss,
    output logic        inst_bus_err
);

    typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

    localparam logic [7:0] TO_LAST = 8'(BUS_TIMEOUT - 1);

    state_t      state;
    logic [7:0]  cnt;
    logic [31:0] pc4_q;

    logic timeout, done_miss, done_ack, done_err, done;

    // timeout fires on the BUS_TIMEOUT-th cycle spent waiting in REQ/DROP
    assign timeout   = (state != IDLE) && !bus_ack && (cnt == TO_LAST);
    assign done_miss = (state == IDLE) && PCTLBMiss && !flush;
    assign done_ack  = (state == REQ) && bus_ack && !flush;
    assign done_err  = (state == REQ) && timeout && !flush;
    assign done      = done_miss | done_ack | done_err;
    assign ready     = flush | done;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            bus_req  <= 1'b0;
            bus_addr <= 32'd0;
            cnt      <= 8'd0;
            pc4_q    <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= 8'd0;
                    if (!flush && !PCTLBMiss) begin
                        state    <= REQ;
                        bus_req  <= 1'b1;
                        bus_addr <= PC;
                        pc4_q    <= PCPlus4;
                    end
                end
                REQ: begin
                    if (bus_ack || timeout) begin
                        state   <= IDLE;
                        bus_req <= 1'b0;
                        cnt     <= 8'd0;
                    end else if (flush) begin
                        // the bus still owes us a reply; keep requesting and drop it
                        state <= DROP;
                        cnt   <= 8'd0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                DROP: begin
                    if (bus_ack || timeout) begin
                        state   <= IDLE;
                        bus_req <= 1'b0;
                        cnt     <= 8'd0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    bus_req <= 1'b0;
                    cnt     <= 8'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            inst_valid    <= 1'b0;
            inst          <= 32'd0;
            inst_pc       <= 32'd0;
            inst_pc_plus4 <= 32'd0;
            inst_tlb_miss <= 1'b0;
            inst_bus_err  <= 1'b0;
        end else if (flush) begin
            inst_valid    <= 1'b0;
            inst          <= 32'd0;
            inst_pc       <= 32'd0;
            inst_pc_plus4 <= 32'd0;
            inst_tlb_miss <= 1'b0;
            inst_bus_err  <= 1'b0;
        end else if (PauseSignal) begin
            inst_valid    <= inst_valid;
        end else if (done) begin
            inst_valid    <= 1'b1;
            inst          <= done_ack ? bus_rdata : 32'd0;
            inst_pc       <= done_miss ? PC : bus_addr;
            inst_pc_plus4 <= done_miss ? PCPlus4 : pc4_q;
            inst_tlb_miss <= done_miss;
            inst_bus_err  <= done_err;
        end else begin
            inst_valid    <= 1'b0;
            inst          <= 32'd0;
            inst_pc       <= 32'd0;
            inst_pc_plus4 <= 32'd0;
            inst_tlb_miss <= 1'b0;
            inst_bus_err  <= 1'b0;
        end
    end

endmodule
